// File: rtl/axis_wacc_pkg.sv
// Shared types and elaboration helpers for the AXI4-Stream weighted accumulator.
package axis_wacc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } wacc_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axis_wacc_lane.sv
// One multiply-accumulate channel; acc_nxt is the value the register takes at the next edge.
module axis_wacc_lane
  import axis_wacc_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int WGT_W    = 8,
  parameter int ACC_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  input  logic [WGT_W-1:0]  wgt,
  output logic [ACC_W-1:0]  acc_nxt,
  output logic              ovf_hit
);

  localparam int PROD_W = DATA_W + WGT_W;
  localparam int EXT_W  = max_int(PROD_W, ACC_W);

  logic [EXT_W-1:0] prod_s;
  logic [EXT_W-1:0] prod_hi_s;
  logic             lost_s;
  logic [ACC_W:0]   sum_s;
  logic             carry_s;
  logic [ACC_W-1:0] acc_r;

  // Product, truncation loss, carry-out and next accumulator value
  always_comb begin
    prod_s    = EXT_W'(data) * EXT_W'(wgt);
    prod_hi_s = prod_s >> ACC_W;
    lost_s    = (prod_hi_s != {EXT_W{1'b0}});
    sum_s     = {1'b0, acc_r} + {1'b0, prod_s[ACC_W-1:0]};
    carry_s   = sum_s[ACC_W];
    if (clr) begin
      acc_nxt = {ACC_W{1'b0}};
    end else if (!en) begin
      acc_nxt = acc_r;
    end else if ((SATURATE != 0) && (carry_s || lost_s)) begin
      acc_nxt = {ACC_W{1'b1}};
    end else begin
      acc_nxt = sum_s[ACC_W-1:0];
    end
    if (en) begin
      ovf_hit = carry_s | lost_s;
    end else begin
      ovf_hit = 1'b0;
    end
  end

  // Accumulator register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_r <= {ACC_W{1'b0}};
    end else begin
      acc_r <= acc_nxt;
    end
  end

endmodule

// File: rtl/axis_weighted_accum.sv
// AXI4-Stream frame reducer: N_CH weighted sums per input frame, streamed out as one result frame.
module axis_weighted_accum
  import axis_wacc_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int WGT_W    = 8,
  parameter int ACC_W    = 32,
  parameter int N_CH     = 3,
  parameter int SATURATE = 0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [N_CH*WGT_W-1:0]   wgt,
  input  logic [DATA_W-1:0]       s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [ACC_W-1:0]        m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    frame_done,
  output logic                    ovf
);

  localparam int              IDX_W    = idx_width(N_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  wacc_state_e             state_r;
  logic [N_CH*WGT_W-1:0]   wgt_q_r;
  logic [IDX_W-1:0]        idx_r;
  logic                    s_tready_r;
  logic                    m_tvalid_r;
  logic                    m_tlast_r;
  logic [ACC_W-1:0]        m_tdata_r;
  logic                    frame_done_r;
  logic                    ovf_r;

  logic [ACC_W-1:0]        acc_nxt_s [N_CH];
  logic [N_CH-1:0]         hit_s;
  logic                    beat_s;
  logic                    out_hs_s;
  logic                    out_end_s;
  logic [N_CH*WGT_W-1:0]   wgt_use_s;
  logic [IDX_W-1:0]        idx_inc_s;
  logic [ACC_W-1:0]        acc_sel_s;

  // Handshake decode, weight source and next-result selection
  always_comb begin
    beat_s    = s_axis_tvalid && s_tready_r;
    out_hs_s  = m_tvalid_r && m_axis_tready;
    out_end_s = out_hs_s && (idx_r == LAST_IDX);
    idx_inc_s = idx_r + IDX_W'(1);
    // The first beat of a frame uses the live weights it is about to capture
    if (state_r == IDLE) begin
      wgt_use_s = wgt;
    end else begin
      wgt_use_s = wgt_q_r;
    end
    acc_sel_s = {ACC_W{1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      if (IDX_W'(k) == idx_inc_s) begin
        acc_sel_s = acc_nxt_s[k];
      end else begin
        acc_sel_s = acc_sel_s;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    axis_wacc_lane #(
      .DATA_W   (DATA_W),
      .WGT_W    (WGT_W),
      .ACC_W    (ACC_W),
      .SATURATE (SATURATE)
    ) u_lane (
      .aclk    (aclk),
      .aresetn (aresetn),
      .clr     (out_end_s),
      .en      (beat_s),
      .data    (s_axis_tdata),
      .wgt     (wgt_use_s[g*WGT_W +: WGT_W]),
      .acc_nxt (acc_nxt_s[g]),
      .ovf_hit (hit_s[g])
    );
  end

  // Frame FSM with registered stream outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r      <= IDLE;
      wgt_q_r      <= {(N_CH*WGT_W){1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      s_tready_r   <= 1'b0;
      m_tvalid_r   <= 1'b0;
      m_tlast_r    <= 1'b0;
      m_tdata_r    <= {ACC_W{1'b0}};
      frame_done_r <= 1'b0;
      ovf_r        <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          s_tready_r <= 1'b1;
          if (beat_s) begin
            wgt_q_r <= wgt;
            ovf_r   <= |hit_s;
            state_r <= ACCUM;
            if (s_axis_tlast) begin
              state_r    <= DRAIN;
              s_tready_r <= 1'b0;
              m_tvalid_r <= 1'b1;
              idx_r      <= {IDX_W{1'b0}};
              m_tdata_r  <= acc_nxt_s[0];
              m_tlast_r  <= (LAST_IDX == {IDX_W{1'b0}});
            end
          end
        end
        ACCUM: begin
          if (beat_s) begin
            ovf_r <= ovf_r | (|hit_s);
            if (s_axis_tlast) begin
              state_r    <= DRAIN;
              s_tready_r <= 1'b0;
              m_tvalid_r <= 1'b1;
              idx_r      <= {IDX_W{1'b0}};
              m_tdata_r  <= acc_nxt_s[0];
              m_tlast_r  <= (LAST_IDX == {IDX_W{1'b0}});
            end
          end
        end
        DRAIN: begin
          if (out_end_s) begin
            state_r      <= IDLE;
            s_tready_r   <= 1'b1;
            m_tvalid_r   <= 1'b0;
            m_tlast_r    <= 1'b0;
            m_tdata_r    <= {ACC_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            frame_done_r <= 1'b1;
          end else if (out_hs_s) begin
            idx_r     <= idx_inc_s;
            m_tdata_r <= acc_sel_s;
            m_tlast_r <= (idx_inc_s == LAST_IDX);
          end
        end
        default: begin
          state_r    <= IDLE;
          s_tready_r <= 1'b0;
          m_tvalid_r <= 1'b0;
        end
      endcase
    end
  end

  assign s_axis_tready = s_tready_r;
  assign m_axis_tdata  = m_tdata_r;
  assign m_axis_tvalid = m_tvalid_r;
  assign m_axis_tlast  = m_tlast_r;
  assign frame_done    = frame_done_r;
  assign ovf           = ovf_r;

endmodule

// File: tb/tb_axis_weighted_accum.sv
// Randomised self-checking bench for axis_weighted_accum against an arithmetic frame model.
module tb_axis_weighted_accum;

  logic clk = 1'b0;
  logic aresetn = 1'b1;
  always #5 clk = ~clk;

  // Main instance: default 3-channel, 32-bit, wrapping
  logic [23:0] wgt;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tlast, m_tready;
  logic        s_tready, m_tvalid, m_tlast, frame_done, ovf;
  logic [31:0] m_tdata;

  // Narrow single-channel instances, wrap (a) and saturate (b), driven in lockstep
  logic [7:0]  sm_wgt;
  logic [31:0] sm_tdata;
  logic        sm_tvalid, sm_tlast, sm_mready;
  logic        sa_tready, sa_tvalid, sa_tlast, sa_done, sa_ovf;
  logic        sb_tready, sb_tvalid, sb_tlast, sb_done, sb_ovf;
  logic [7:0]  sa_tdata, sb_tdata;

  axis_weighted_accum dut (
    .aclk(clk), .aresetn(aresetn), .wgt(wgt),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .frame_done(frame_done), .ovf(ovf)
  );

  axis_weighted_accum #(.ACC_W(8), .N_CH(1), .SATURATE(0)) dut_wrap (
    .aclk(clk), .aresetn(aresetn), .wgt(sm_wgt),
    .s_axis_tdata(sm_tdata), .s_axis_tvalid(sm_tvalid), .s_axis_tready(sa_tready),
    .s_axis_tlast(sm_tlast), .m_axis_tdata(sa_tdata), .m_axis_tvalid(sa_tvalid),
    .m_axis_tready(sm_mready), .m_axis_tlast(sa_tlast), .frame_done(sa_done), .ovf(sa_ovf)
  );

  axis_weighted_accum #(.ACC_W(8), .N_CH(1), .SATURATE(1)) dut_sat (
    .aclk(clk), .aresetn(aresetn), .wgt(sm_wgt),
    .s_axis_tdata(sm_tdata), .s_axis_tvalid(sm_tvalid), .s_axis_tready(sb_tready),
    .s_axis_tlast(sm_tlast), .m_axis_tdata(sb_tdata), .m_axis_tvalid(sb_tvalid),
    .m_axis_tready(sm_mready), .m_axis_tlast(sb_tlast), .frame_done(sb_done), .ovf(sb_ovf)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] frame_q[$];
  logic [63:0] exp_q[3];
  bit          exp_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: sum of data*w over frame_q, wrapping or clamping at 2^acc_w; ov = any step overflowed
  function automatic logic [63:0] ref_sum(input int acc_w, input bit sat, input logic [7:0] w,
                                          output bit ov);
    logic [63:0] lim, acc, prod;
    lim = 64'd1 << acc_w;
    acc = 64'd0;
    ov  = 1'b0;
    foreach (frame_q[i]) begin
      prod = 64'(frame_q[i]) * 64'(w);
      if ((prod >= lim) || ((acc + (prod % lim)) >= lim)) begin
        ov  = 1'b1;
        acc = sat ? (lim - 64'd1) : ((acc + prod) % lim);
      end else begin
        acc = acc + prod;
      end
    end
    return acc;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_mvalid"}, m_tvalid, 1'b0);
    check({tag, "_mdata"},  m_tdata, 32'd0);
    check({tag, "_mlast"},  m_tlast, 1'b0);
    check({tag, "_sready"}, s_tready, 1'b0);
    check({tag, "_done"},   frame_done, 1'b0);
    check({tag, "_ovf"},    ovf, 1'b0);
  endtask

  task automatic fill_ramp(input int n);
    frame_q.delete();
    for (int i = 1; i <= n; i++) frame_q.push_back(32'(i));
  endtask

  // Send frame_q to the main instance, then drain and check its three results
  task automatic run_main(input bit gaps, input bit jitter, input int stall_at, input int stall_len);
    logic [23:0] wcfg;
    bit          o;
    int          guard, idx, cyc, stalled;
    wcfg    = wgt;
    exp_ovf = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_q[k] = ref_sum(32, 1'b0, wcfg[k*8 +: 8], o);
      exp_ovf  = exp_ovf | o;
    end
    for (int i = 0; i < frame_q.size(); i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          @(negedge clk);
          s_tvalid = 1'b0;
          if (jitter && i > 0) wgt = $urandom;
        end
      end
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = frame_q[i];
      s_tlast  = (i == frame_q.size() - 1);
      if (jitter && i > 0) wgt = $urandom;
      guard = 0;
      while (!s_tready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (guard == 20) check("sready_timeout", s_tready, 1'b1);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    wgt      = wcfg;
    check("drain_latency", m_tvalid, 1'b1);
    idx = 0; cyc = 0; stalled = 0;
    while (idx < 3 && cyc < 100) begin
      check("drain_sready", s_tready, 1'b0);
      m_tready = !(idx == stall_at && stalled < stall_len);
      if (!m_tready) stalled++;
      if (m_tvalid) begin
        check($sformatf("result%0d", idx), m_tdata, exp_q[idx]);
        check($sformatf("tlast%0d", idx), m_tlast, (idx == 2));
        if (m_tready) idx++;
      end
      @(negedge clk);
      cyc++;
    end
    m_tready = 1'b1;
    if (idx < 3) check("drain_timeout", 64'(idx), 64'd3);
    check("frame_done", frame_done, 1'b1);
    check("mvalid_after", m_tvalid, 1'b0);
    check("sready_after", s_tready, 1'b1);
    check("ovf", ovf, exp_ovf);
    @(negedge clk);
    check("frame_done_pulse", frame_done, 1'b0);
  endtask

  // Send frame_q to both narrow instances and check their single result
  task automatic run_small();
    logic [63:0] ea, eb;
    bit          oa, ob;
    ea = ref_sum(8, 1'b0, sm_wgt, oa);
    eb = ref_sum(8, 1'b1, sm_wgt, ob);
    for (int i = 0; i < frame_q.size(); i++) begin
      @(negedge clk);
      check("sm_sready", sa_tready & sb_tready, 1'b1);
      sm_tvalid = 1'b1;
      sm_tdata  = frame_q[i];
      sm_tlast  = (i == frame_q.size() - 1);
    end
    @(negedge clk);
    sm_tvalid = 1'b0;
    sm_tlast  = 1'b0;
    check("wrap_valid", sa_tvalid, 1'b1);
    check("wrap_data",  sa_tdata, ea);
    check("wrap_last",  sa_tlast, 1'b1);
    check("wrap_ovf",   sa_ovf, oa);
    check("sat_valid",  sb_tvalid, 1'b1);
    check("sat_data",   sb_tdata, eb);
    check("sat_last",   sb_tlast, 1'b1);
    check("sat_ovf",    sb_ovf, ob);
    @(negedge clk);
    check("wrap_done", sa_done, 1'b1);
    check("sat_done",  sb_done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wgt = 24'd0; s_tdata = 32'd0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    sm_wgt = 8'd0; sm_tdata = 32'd0; sm_tvalid = 1'b0; sm_tlast = 1'b0; sm_mready = 1'b1;
    #2 aresetn = 1'b0;
    #1 check_reset_state("reset");
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    check("idle_sready", s_tready, 1'b1);

    // 50-beat ramp, weights {3,2,1}
    wgt = {8'd3, 8'd2, 8'd1};
    fill_ramp(50);
    run_main(1'b0, 1'b0, -1, 0);
    // Same frame, output stalled 5 cycles on the second result
    run_main(1'b0, 1'b0, 1, 5);
    // Single-beat frame
    frame_q.delete();
    frame_q.push_back(32'd7);
    run_main(1'b0, 1'b0, -1, 0);
    // Input gaps plus weights changing after the first beat
    fill_ramp(50);
    run_main(1'b1, 1'b1, -1, 0);

    // Narrow wrap/saturate: {200,200} with weight 1, then random small frames
    sm_wgt = 8'd1;
    frame_q.delete();
    frame_q.push_back(32'd200);
    frame_q.push_back(32'd200);
    run_small();
    for (int f = 0; f < 5; f++) begin
      sm_wgt = 8'($urandom_range(0, 3));
      frame_q.delete();
      for (int i = 0; i < $urandom_range(1, 4); i++) frame_q.push_back(32'($urandom_range(0, 300)));
      run_small();
    end

    // Random full-width frames (32-bit wrap and ovf exercised)
    for (int f = 0; f < 6; f++) begin
      wgt = $urandom;
      frame_q.delete();
      for (int i = 0; i < $urandom_range(1, 20); i++) frame_q.push_back($urandom);
      run_main(1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 2), $urandom_range(0, 4));
    end

    // Reset in the middle of an overflowing frame, then a clean frame
    wgt = {8'd3, 8'd2, 8'd1};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = 32'hFFFF_FFFF;
      s_tlast  = 1'b0;
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    check("pre_reset_ovf", ovf, 1'b1);
    aresetn = 1'b0;
    #1 check_reset_state("midreset");
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    fill_ramp(50);
    run_main(1'b0, 1'b0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
